game_sequencer: RTL and testbench

Top-level game controller for the reaction/chord game. It sequences the four-digit seven-segment output stage through attract, play and result modes. During play it issues random target chords, checks the player's 12 key switches against them, keeps score and counts down the game timer. Its outputs drive the display stage's `state`, `chord`, `time_or_score`, `random` and `blinClock` inputs directly.

---
 rtl/game_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: attract / play / result controller for the chord game.
// Issues target chords, scores key hits, runs game and result timers.
module game_sequencer #(
   parameter int TICKS_PER_SEC  = 50_000_000,
   parameter int GAME_SECONDS   = 30,
   parameter int RESULT_SECONDS = 5,
   parameter int BLINK_TICKS    = 12_500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [11:0] keys,
   input  logic [31:0] random,
   output logic [1:0]  disp_state,
   output logic [11:0] chord,
   output logic [31:0] time_or_score,
   output logic        blin_tick,
   output logic [13:0] score
);

   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int BW = $clog2(BLINK_TICKS);

   localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
   localparam logic [6:0]    GAME_S    = 7'(GAME_SECONDS);
   localparam logic [6:0]    RES_MAX   = 7'(RESULT_SECONDS - 1);
   localparam logic [13:0]   SCORE_MAX = 14'd9999;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PLAY   = 2'd1,
      S_RESULT = 2'd2,
      S_BAD    = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state;
   logic            r_start_q;
   logic [BW-1:0]   r_blink_cnt;
   logic [BW-1:0]   w_blink_cnt;
   logic            r_blin;
   logic            w_blin;
   logic [TW-1:0]   r_tick_cnt;
   logic [TW-1:0]   w_tick_cnt;
   logic [6:0]      r_timer;
   logic [6:0]      w_timer;
   logic [6:0]      r_res_sec;
   logic [6:0]      w_res_sec;
   logic [13:0]     r_score;
   logic [13:0]     w_score;
   logic            r_armed;
   logic            w_armed;
   logic [11:0]     r_chord;
   logic [11:0]     w_chord;
   logic [31:0]     r_tos;
   logic [31:0]     w_tos;

   logic            w_start_edge;
   logic            w_launch;
   logic            w_tick_wrap;
   logic            w_blink_wrap;
   logic            w_hit;
   logic [11:0]     w_new_chord;
   logic [13:0]     w_score_inc;
   logic            w_unused_rand;

   // The upper random bits belong to the display stage only.
   assign w_unused_rand = ^random[31:12];

   assign w_start_edge = start & ~r_start_q;
   assign w_tick_wrap  = (r_tick_cnt == TICK_MAX);
   assign w_blink_wrap = (r_blink_cnt == BLINK_MAX);
   assign w_hit        = r_armed & (keys == r_chord);
   assign w_new_chord  = (random[11:0] == 12'h000) ? 12'h001 : random[11:0];
   assign w_score_inc  = (r_score == SCORE_MAX) ? r_score : r_score + 14'd1;

   assign disp_state    = r_state;
   assign chord         = r_chord;
   assign time_or_score = r_tos;
   assign blin_tick     = r_blin;
   assign score         = r_score;

   // State register; a start button held through reset reads as old.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_start_q <= 1'b1;
      end else begin
         r_state   <= w_state;
         r_start_q <= start;
      end
   end

   // Datapath registers: counters, score, chord and display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_blin      <= 1'b0;
         r_tick_cnt  <= '0;
         r_timer     <= '0;
         r_res_sec   <= '0;
         r_score     <= '0;
         r_armed     <= 1'b1;
         r_chord     <= '0;
         r_tos       <= '0;
      end else begin
         r_blink_cnt <= w_blink_cnt;
         r_blin      <= w_blin;
         r_tick_cnt  <= w_tick_cnt;
         r_timer     <= w_timer;
         r_res_sec   <= w_res_sec;
         r_score     <= w_score;
         r_armed     <= w_armed;
         r_chord     <= w_chord;
         r_tos       <= w_tos;
      end
   end

   // Next-state and next-output logic for all three game modes.
   always_comb begin
      w_state     = r_state;
      w_blink_cnt = '0;
      w_blin      = 1'b0;
      w_tick_cnt  = r_tick_cnt;
      w_timer     = r_timer;
      w_res_sec   = r_res_sec;
      w_score     = r_score;
      w_armed     = r_armed;
      w_chord     = r_chord;
      w_tos       = r_tos;
      w_launch    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_blink_cnt = w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
            w_blin      = w_blink_wrap;
            w_chord     = '0;
            w_tos       = '0;
            w_launch    = w_start_edge;
         end
         S_PLAY: begin
            w_tick_cnt = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
            if (w_hit) begin
               w_score = w_score_inc;
               w_armed = 1'b0;
               w_chord = w_new_chord;
            end else if (!r_armed && keys == 12'h000) begin
               w_armed = 1'b1;
            end
            if (w_tick_wrap && r_timer > 7'd1) begin
               w_timer = r_timer - 7'd1;
            end else if (w_tick_wrap) begin
               w_timer   = '0;
               w_res_sec = '0;
               w_chord   = '0;
               w_state   = S_RESULT;
            end
            if (w_state == S_RESULT) begin
               w_tos = {18'd0, w_score};
            end else begin
               w_tos = {25'd0, w_timer};
            end
         end
         S_RESULT: begin
            w_chord    = '0;
            w_tos      = {18'd0, r_score};
            w_tick_cnt = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
            if (w_tick_wrap) begin
               if (r_res_sec == RES_MAX) begin
                  w_res_sec = '0;
                  w_tos     = '0;
                  w_state   = S_IDLE;
               end else begin
                  w_res_sec = r_res_sec + 7'd1;
               end
            end
            w_launch = w_start_edge;
         end
         S_BAD: begin
            w_state    = S_IDLE;
            w_tick_cnt = '0;
            w_timer    = '0;
            w_res_sec  = '0;
            w_armed    = 1'b1;
            w_chord    = '0;
            w_tos      = '0;
         end
      endcase

      // A new game wins over result expiry.
      if (w_launch) begin
         w_state     = S_PLAY;
         w_tick_cnt  = '0;
         w_timer     = GAME_S;
         w_res_sec   = '0;
         w_score     = '0;
         w_armed     = 1'b1;
         w_chord     = w_new_chord;
         w_tos       = {25'd0, GAME_S};
         w_blink_cnt = '0;
         w_blin      = 1'b0;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard bench for game_sequencer.
// Expected outputs are queued per cycle; a monitor pops and compares.
module tb_game_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [11:0] keys_a = '0;
   logic [11:0] keys_b = '0;
   logic [31:0] rnd_a = '0;
   logic [31:0] rnd_b = '0;
   logic [1:0]  ds_a, ds_b;
   logic [11:0] ch_a, ch_b;
   logic [31:0] tos_a, tos_b;
   logic        bl_a, bl_b;
   logic [13:0] sc_a, sc_b;

   game_sequencer #(
      .TICKS_PER_SEC(4), .GAME_SECONDS(3),
      .RESULT_SECONDS(2), .BLINK_TICKS(3)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .keys(keys_a), .random(rnd_a),
      .disp_state(ds_a), .chord(ch_a),
      .time_or_score(tos_a), .blin_tick(bl_a), .score(sc_a)
   );

   game_sequencer #(
      .TICKS_PER_SEC(10000), .GAME_SECONDS(3),
      .RESULT_SECONDS(2), .BLINK_TICKS(3)
   ) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .keys(keys_b), .random(rnd_b),
      .disp_state(ds_b), .chord(ch_b),
      .time_or_score(tos_b), .blin_tick(bl_b), .score(sc_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int          cyc;
      int          inst;
      string       nm;
      logic [1:0]  ds;
      logic [11:0] ch;
      logic [31:0] tos;
      logic        bl;
      logic [13:0] sc;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   n_chk = 0;
   int   n_err = 0;
   logic [1:0]  g_ds;
   logic [11:0] g_ch;
   logic [31:0] g_tos;
   logic        g_bl;
   logic [13:0] g_sc;

   task automatic push(input int d, input int inst, input string nm,
                       input logic [1:0] ds, input logic [11:0] ch,
                       input logic [31:0] tos, input logic bl,
                       input logic [13:0] sc);
      exp_t e;
      e.cyc  = cyc + d;
      e.inst = inst;
      e.nm   = nm;
      e.ds   = ds;
      e.ch   = ch;
      e.tos  = tos;
      e.bl   = bl;
      e.sc   = sc;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every queued expectation due this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         m = q.pop_front();
         n_chk++;
         if (m.inst == 1) begin
            g_ds = ds_a; g_ch = ch_a; g_tos = tos_a;
            g_bl = bl_a; g_sc = sc_a;
         end else begin
            g_ds = ds_b; g_ch = ch_b; g_tos = tos_b;
            g_bl = bl_b; g_sc = sc_b;
         end
         if (m.cyc != cyc || g_ds !== m.ds || g_ch !== m.ch ||
             g_tos !== m.tos || g_bl !== m.bl || g_sc !== m.sc) begin
            n_err++;
            $display("FAIL %s cyc=%0d/%0d got ds=%0d ch=%h tos=%0d bl=%0d sc=%0d want ds=%0d ch=%h tos=%0d bl=%0d sc=%0d",
                     m.nm, cyc, m.cyc, g_ds, g_ch, g_tos, g_bl, g_sc,
                     m.ds, m.ch, m.tos, m.bl, m.sc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, then attract blink every 3 cycles.
      step(2);
      push(0, 1, "reset", 2'd0, 12'h000, 32'd0, 1'b0, 14'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++)
         push(k, 1, "blink", 2'd0, 12'h000, 32'd0, (k % 3 == 0), 14'd0);
      step(8);

      // Start held through reset must not launch a game.
      rst_n = 1'b0;
      start_a = 1'b1;
      step(2);
      push(0, 1, "reset2", 2'd0, 12'h000, 32'd0, 1'b0, 14'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++)
         push(k, 1, "held", 2'd0, 12'h000, 32'd0, (k == 3), 14'd0);
      step(3);
      start_a = 1'b0;
      push(1, 1, "held_rel", 2'd0, 12'h000, 32'd0, 1'b0, 14'd0);
      step(1);

      // Full timer run: 12 play cycles, 8 result cycles, back to attract.
      rnd_a = 32'h0000_0A5C;
      start_a = 1'b1;
      for (int k = 1; k <= 24; k++)
         push(k, 1, "run",
              (k <= 12) ? 2'd1 : (k <= 20) ? 2'd2 : 2'd0,
              (k <= 12) ? 12'hA5C : 12'h000,
              (k <= 4) ? 32'd3 : (k <= 8) ? 32'd2 : (k <= 12) ? 32'd1 : 32'd0,
              (k == 24), 14'd0);
      step(24);

      // Scoring and re-arm; zero random gives chord 001.
      start_a = 1'b0;
      rnd_a = 32'h0;
      push(1, 1, "idle2", 2'd0, 12'h000, 32'd0, 1'b0, 14'd0);
      step(1);
      start_a = 1'b1;
      push(1, 1, "start0", 2'd1, 12'h001, 32'd3, 1'b0, 14'd0);
      step(1);
      keys_a = 12'h001;
      rnd_a = 32'h0000_0123;
      push(1, 1, "hit1", 2'd1, 12'h123, 32'd3, 1'b0, 14'd1);
      step(1);
      keys_a = 12'h123;
      rnd_a = 32'h0000_0456;
      push(1, 1, "noarm1", 2'd1, 12'h123, 32'd3, 1'b0, 14'd1);
      step(1);
      push(1, 1, "noarm2", 2'd1, 12'h123, 32'd3, 1'b0, 14'd1);
      step(1);
      keys_a = 12'h000;
      push(1, 1, "rearm", 2'd1, 12'h123, 32'd2, 1'b0, 14'd1);
      step(1);
      keys_a = 12'h123;
      push(1, 1, "hit2", 2'd1, 12'h456, 32'd2, 1'b0, 14'd2);
      step(1);

      // Hit in the last play cycle is scored into the result.
      keys_a = 12'h000;
      for (int k = 6; k <= 11; k++) begin
         push(1, 1, "tail", 2'd1, 12'h456,
              (k < 8) ? 32'd2 : 32'd1, 1'b0, 14'd2);
         step(1);
      end
      keys_a = 12'h456;
      push(1, 1, "lasthit", 2'd2, 12'h000, 32'd3, 1'b0, 14'd3);
      step(1);
      keys_a = 12'h000;
      start_a = 1'b0;
      push(1, 1, "result", 2'd2, 12'h000, 32'd3, 1'b0, 14'd3);
      step(1);
      rnd_a = 32'h0000_0789;
      start_a = 1'b1;
      push(1, 1, "restart", 2'd1, 12'h789, 32'd3, 1'b0, 14'd0);
      step(1);
      start_a = 1'b0;
      push(1, 1, "ign1", 2'd1, 12'h789, 32'd3, 1'b0, 14'd0);
      step(1);
      start_a = 1'b1;
      push(1, 1, "ign2", 2'd1, 12'h789, 32'd3, 1'b0, 14'd0);
      step(1);

      // Saturation on the long-game instance.
      rnd_b = 32'h0000_000F;
      start_b = 1'b1;
      push(1, 2, "sat_start", 2'd1, 12'h00F, 32'd3, 1'b0, 14'd0);
      step(1);
      for (int i = 0; i < 9998; i++) begin
         keys_b = 12'h00F;
         step(1);
         keys_b = 12'h000;
         step(1);
      end
      push(0, 2, "sat_pre", 2'd1, 12'h00F, 32'd2, 1'b0, 14'd9998);
      keys_b = 12'h00F;
      push(1, 2, "sat_9999", 2'd1, 12'h00F, 32'd2, 1'b0, 14'd9999);
      step(1);
      keys_b = 12'h000;
      step(1);
      rnd_b = 32'h0000_00F0;
      keys_b = 12'h00F;
      push(1, 2, "sat_hold", 2'd1, 12'h0F0, 32'd2, 1'b0, 14'd9999);
      step(1);
      rnd_b = 32'h0000_000F;
      keys_b = 12'h0F0;
      push(1, 2, "sat_disarm", 2'd1, 12'h0F0, 32'd1, 1'b0, 14'd9999);
      step(2);

      // Asynchronous reset mid-play: checked before any clock edge.
      rst_n = 1'b0;
      push(0, 2, "async_b", 2'd0, 12'h000, 32'd0, 1'b0, 14'd0);
      push(0, 1, "async_a", 2'd0, 12'h000, 32'd0, 1'b0, 14'd0);
      step(2);
      rst_n = 1'b1;
      step(2);

      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
